// File: rtl/vcu_bram_loader.sv
// vcu_bram_loader: accepts one AXI-stream burst per start and writes it into
// a BRAM port as full-word writes starting at a latched base address, then
// raises memWRTDone until the VCU acknowledges with vcuDone.
//
//   state | meaning
//   ------+----------------------------------------------------------------
//   IDLE  | waiting for start; no stream words accepted
//   LOAD  | s_tready high, each handshake produces one BRAM write next cycle
//   DRAIN | last write pulse is on the BRAM port; lets it land before DONE
//   DONE  | memWRTDone high until vcuDone hands control back
`timescale 1ns/1ps

module vcu_bram_loader #(
  parameter int wordSize   = 32,
  parameter int memDepth   = 30,
  parameter int LOAD_WORDS = 512
) (
  input  logic                  clk,
  input  logic                  RESET,
  input  logic                  start,
  input  logic [memDepth-1:0]   baseAddr,
  input  logic [wordSize-1:0]   s_tdata,
  input  logic                  s_tvalid,
  input  logic                  s_tlast,
  output logic                  s_tready,
  input  logic                  vcuDone,
  output logic [wordSize-1:0]   BRAMDataOut,
  output logic [memDepth+1:0]   BRAMaddrByte,
  output logic [3:0]            BRAMWREN,
  output logic                  BRAMENMEM,
  output logic                  memWRTDone,
  output logic                  busy,
  output logic                  err
);

  localparam int CW = $clog2(LOAD_WORDS + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(LOAD_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic [memDepth-1:0]   base_q, base_d;
  logic                  err_q, err_d;
  logic [wordSize-1:0]   data_q, data_d;
  logic [memDepth+1:0]   addr_q, addr_d;
  logic [3:0]            wren_q, wren_d;
  logic                  en_q, en_d;

  logic                  hs;
  logic                  at_last;
  logic [memDepth-1:0]   word_addr;

  // Handshake qualifier, final-word detect and wrapping word address.
  assign hs        = s_tvalid && (state_q == LOAD);
  assign at_last   = (count_q == LAST_CNT);
  assign word_addr = base_q + memDepth'(count_q);

  // Next-state, counter, error and registered BRAM write port.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    base_d  = base_q;
    err_d   = err_q;
    data_d  = data_q;
    addr_d  = addr_q;
    wren_d  = 4'h0;
    en_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          base_d  = baseAddr;
          count_d = '0;
          err_d   = 1'b0;
        end
      end
      LOAD: begin
        if (hs) begin
          en_d    = 1'b1;
          wren_d  = 4'hF;
          data_d  = s_tdata;
          addr_d  = {word_addr, 2'b00};
          count_d = count_q + CW'(1);
          // tlast must coincide exactly with the final word; either
          // disagreement is flagged but the load still ends normally.
          if (s_tlast != at_last) begin
            err_d = 1'b1;
          end
          if (s_tlast || at_last) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        state_d = DONE;
      end
      DONE: begin
        if (vcuDone) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset also kills any in-flight write pulse.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      count_q <= '0;
      base_q  <= '0;
      err_q   <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
      wren_q  <= 4'h0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      base_q  <= base_d;
      err_q   <= err_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      wren_q  <= wren_d;
      en_q    <= en_d;
    end
  end

  assign s_tready     = (state_q == LOAD);
  assign busy         = (state_q == LOAD) || (state_q == DRAIN);
  assign memWRTDone   = (state_q == DONE);
  assign err          = err_q;
  assign BRAMDataOut  = data_q;
  assign BRAMaddrByte = addr_q;
  assign BRAMWREN     = wren_q;
  assign BRAMENMEM    = en_q;

endmodule

// File: doc/vcu_bram_loader.md
VCU_BRAM_LOADER -- requirements
Module: vcu_bram_loader

Interface
REQ-001 Parameter wordSize, default 32, stream and BRAM data width; SHALL be 32.
REQ-002 Parameter memDepth, default 30, BRAM word-address width.
REQ-003 Parameter LOAD_WORDS, default 512, words per load; range 1..2^memDepth.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 RESET  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  arms one load; ignored outside IDLE.
REQ-007 baseAddr  input  memDepth  BRAM word address of the first word; latched on accepted start.
REQ-008 s_tdata  input  wordSize  stream data.
REQ-009 s_tvalid  input  1  stream data valid.
REQ-010 s_tlast  input  1  marks the final stream word.
REQ-011 s_tready  output  1  loader accepts a word.
REQ-012 vcuDone  input  1  VCU done; releases memWRTDone.
REQ-013 BRAMDataOut  output  wordSize  BRAM write data.
REQ-014 BRAMaddrByte  output  memDepth+2  BRAM byte address.
REQ-015 BRAMWREN  output  4  BRAM byte write enables.
REQ-016 BRAMENMEM  output  1  BRAM port enable.
REQ-017 memWRTDone  output  1  load complete; drives the VCU memWRTDone input.
REQ-018 busy  output  1  high in LOAD or DRAIN.
REQ-019 err  output  1  sticky tlast mismatch flag.

Function
REQ-020 FSM states SHALL be IDLE, LOAD, DRAIN, DONE.
REQ-021 IDLE->LOAD on start=1; latches baseAddr, clears the word counter and err.
REQ-022 In LOAD, s_tready SHALL be 1. In all other states it SHALL be 0. A handshake is s_tvalid&s_tready at a rising edge.
REQ-023 On each handshake, registered BRAM outputs SHALL be driven in the following cycle only: BRAMENMEM=1, BRAMWREN=4'hF, BRAMDataOut=s_tdata, BRAMaddrByte={(baseAddr+count) mod 2^memDepth, 2'b00}.
REQ-024 With no handshake, BRAMENMEM=0 and BRAMWREN=0 in the next cycle; data and address hold their last values.
REQ-025 count SHALL increment per handshake. Width is clog2(LOAD_WORDS+1).
REQ-026 Address wraps modulo 2^memDepth with no error.
REQ-027 LOAD->DRAIN on a handshake when count==LOAD_WORDS-1 or s_tlast=1, whichever occurs first.
REQ-028 DRAIN->DONE unconditionally after one cycle, so the final write pulse completes before memWRTDone rises.
REQ-029 memWRTDone SHALL be 1 exactly while the state is DONE.
REQ-030 err is set in either of two cases: s_tlast=1 on a handshake with count<LOAD_WORDS-1 (early, load ends short), or s_tlast=0 on the handshake with count==LOAD_WORDS-1 (missing, load completes).
REQ-031 err holds until the next accepted start or reset.
REQ-032 DONE->IDLE on vcuDone=1; memWRTDone falls at that edge.
REQ-033 vcuDone in any other state SHALL be ignored.
REQ-034 start while busy or in DONE SHALL be ignored. start and vcuDone together in DONE: return to IDLE only; start is not captured.
REQ-035 Gaps in s_tvalid SHALL stall the load indefinitely with no timeout.

Reset
REQ-036 While RESET=0, all of the following SHALL be 0: state=IDLE, count, latched base, s_tready, BRAMDataOut, BRAMaddrByte, BRAMWREN, BRAMENMEM, memWRTDone, busy, err.
REQ-037 Reset mid-LOAD SHALL abandon the load immediately. No further BRAM write SHALL occur. Any in-flight write pulse is cleared asynchronously.
REQ-038 After reset release, the first accepted start begins a fresh load.

Verification (bench uses LOAD_WORDS=4, memDepth=30)
REQ-039 Nominal: baseAddr=0x10, start, words 0xA0..0xA3 back-to-back with tlast on the 4th -> write pulses at byte addresses 0x40,0x44,0x48,0x4C; memWRTDone=1 two cycles after the 4th handshake; err=0.
REQ-040 Backpressure gaps: s_tvalid toggling 1,0,0,1... -> exactly 4 write pulses, none during gaps, data in order.
REQ-041 Early tlast on the 2nd word -> 2 writes, memWRTDone asserts, err=1. Next start clears err to 0.
REQ-042 Wrap: baseAddr=2^30-2 -> byte addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
REQ-043 RESET=0 after the 2nd handshake -> all outputs 0 within the same cycle, no 3rd write. A new start after release writes from the new base.
REQ-044 Handshake release: in DONE, start=1 is ignored. vcuDone=1 -> memWRTDone=0 at the next edge and state IDLE. vcuDone in IDLE has no effect.
